lif_neuron_core: RTL and testbench

Leaky integrate-and-fire neuron core for the tinysnn design. It accumulates an 8-bit input current into a membrane potential on each integration tick and applies a shift-based leak. When the potential reaches threshold it fires a single-cycle spike, then optionally enters a refractory period. It sits directly upstream of the chip top: it consumes `ui_in` as current and produces the spike and potential signals the top drives onto `uo_out`/`uio_out`.

---
 rtl/snn_pkg.sv | 16 +
 rtl/lif_neuron_core_if.sv | 30 +++
 rtl/snn_tick_gen.sv | 29 ++
 rtl/lif_neuron_core.sv | 133 +++++++++++++
 tb/tb_lif_neuron_core.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types and default constants for the tinysnn LIF neuron.
// Refractory logic is compiled in only when SNN_REFRACTORY_EN is defined.
package snn_pkg;

  typedef enum logic {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } state_e;

  localparam int unsigned POT_W_DEF        = 10;
  localparam int unsigned LEAK_SHIFT_DEF   = 3;
  localparam int unsigned THRESHOLD_DEF    = 200;
  localparam int unsigned REFRAC_TICKS_DEF = 4;
  localparam logic [23:0] TICK_DIV_DEF     = 24'd10_000_000;

endpackage

// File: rtl/lif_neuron_core_if.sv
// Current-in / spike-out bundle between the chip top and the neuron core.
// Option: SNN_REFRACTORY_EN (refractory is tied 0 when undefined).
interface lif_neuron_core_if;

  logic       ena;
  logic [7:0] current_in;
  logic       spike;
  logic [7:0] potential;
  logic       refractory;
  logic [7:0] spike_count;

  modport master (
    output ena,
    output current_in,
    input  spike,
    input  potential,
    input  refractory,
    input  spike_count
  );

  modport slave (
    input  ena,
    input  current_in,
    output spike,
    output potential,
    output refractory,
    output spike_count
  );

endinterface

// File: rtl/snn_tick_gen.sv
// Integration tick divider: one tick every TICK_DIV enabled clk cycles.
// Holds its count while ena is low.
module snn_tick_gen
  import snn_pkg::*;
#(
  parameter logic [23:0] TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);

  localparam logic [23:0] LAST = TICK_DIV - 24'd1;

  logic [23:0] cnt;

  assign tick = ena && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 24'd1;
    end
  end

endmodule

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: shift leak, saturating integrate, spike.
// Option: SNN_REFRACTORY_EN adds the REFRACT state and refractory output.
module lif_neuron_core
  import snn_pkg::*;
#(
  parameter int unsigned POT_W        = POT_W_DEF,
  parameter int unsigned LEAK_SHIFT   = LEAK_SHIFT_DEF,
  parameter int unsigned THRESHOLD    = THRESHOLD_DEF,
  parameter int unsigned REFRAC_TICKS = REFRAC_TICKS_DEF,
  parameter logic [23:0] TICK_DIV     = TICK_DIV_DEF
) (
  input logic              clk,
  input logic              rst_n,
  lif_neuron_core_if.slave bus
);

  localparam int unsigned VW = POT_W + 1;
  localparam logic [VW-1:0] VMAX = {1'b0, {POT_W{1'b1}}};
  localparam logic [POT_W-1:0] THR = POT_W'(THRESHOLD);

  logic             tick;
  logic [POT_W-1:0] v, v_n;
  logic [POT_W-1:0] leak;
  logic [VW-1:0]    v_sum;
  logic [POT_W-1:0] v_sat;
  logic             fire;
  logic             spike_q, spike_n;
  logic [7:0]       cnt_q, cnt_n;

  snn_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (bus.ena),
    .tick  (tick)
  );

  // Wide sum cannot wrap: v - leak >= 0 and the carry bit catches overflow
  assign leak  = v >> LEAK_SHIFT;
  assign v_sum = {1'b0, v} - {1'b0, leak} + VW'(bus.current_in);
  assign v_sat = (v_sum > VMAX) ? {POT_W{1'b1}} : v_sum[POT_W-1:0];
  assign fire  = (v_sat >= THR);

`ifdef SNN_REFRACTORY_EN
  localparam int unsigned RW =
    (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;

  state_e        state, state_n;
  logic [RW-1:0] rc, rc_n;

  always_comb begin
    state_n = state;
    rc_n    = rc;
    v_n     = v;
    cnt_n   = cnt_q;
    spike_n = 1'b0;
    if (tick) begin
      unique case (1'b1)
        (state == ST_INTEGRATE): begin
          if (fire) begin
            v_n     = '0;
            spike_n = 1'b1;
            cnt_n   = cnt_q + 8'd1;
            if (REFRAC_TICKS != 0) begin
              rc_n    = RW'(REFRAC_TICKS);
              state_n = ST_REFRACT;
            end
          end else begin
            v_n = v_sat;
          end
        end
        (state == ST_REFRACT): begin
          v_n  = '0;
          rc_n = rc - RW'(1);
          if (rc == RW'(1)) state_n = ST_INTEGRATE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INTEGRATE;
      rc    <= '0;
    end else begin
      state <= state_n;
      rc    <= rc_n;
    end
  end

  assign bus.refractory = (state == ST_REFRACT);
`else
  logic unused_refrac;

  assign unused_refrac = (REFRAC_TICKS != 0);

  always_comb begin
    v_n     = v;
    cnt_n   = cnt_q;
    spike_n = 1'b0;
    if (tick) begin
      if (fire) begin
        v_n     = '0;
        spike_n = 1'b1;
        cnt_n   = cnt_q + 8'd1;
      end else begin
        v_n = v_sat;
      end
    end
  end

  assign bus.refractory = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v       <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      v       <= v_n;
      spike_q <= spike_n;
      cnt_q   <= cnt_n;
    end
  end

  assign bus.spike       = spike_q;
  assign bus.spike_count = cnt_q;
  assign bus.potential   = v[POT_W-1 -: 8];

endmodule

// File: tb/tb_lif_neuron_core.sv
// Bench for lif_neuron_core: three configurations against a tick-level model.
// Honours SNN_REFRACTORY_EN the same way as the design.
module tb_lif_neuron_core;

  localparam int N = 3;
`ifdef SNN_REFRACTORY_EN
  localparam int RT  = 4;
  localparam int PER = 10;
`else
  localparam int RT  = 0;
  localparam int PER = 6;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] cur = 8'd0;

  always #5 clk = ~clk;

  lif_neuron_core_if ifa ();
  lif_neuron_core_if ifb ();
  lif_neuron_core_if ifc ();

  assign ifa.ena = ena;
  assign ifb.ena = ena;
  assign ifc.ena = ena;
  assign ifa.current_in = cur;
  assign ifb.current_in = cur;
  assign ifc.current_in = cur;

  lif_neuron_core #(
    .POT_W(10), .LEAK_SHIFT(3), .THRESHOLD(200),
    .REFRAC_TICKS(4), .TICK_DIV(24'd1)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

  lif_neuron_core #(
    .POT_W(10), .LEAK_SHIFT(3), .THRESHOLD(1023),
    .REFRAC_TICKS(4), .TICK_DIV(24'd1)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  lif_neuron_core #(
    .POT_W(10), .LEAK_SHIFT(3), .THRESHOLD(200),
    .REFRAC_TICKS(4), .TICK_DIV(24'd3)
  ) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  logic [N-1:0] a_spk, a_ref;
  logic [7:0]   a_pot [N];
  logic [7:0]   a_cnt [N];

  assign a_spk = {ifc.spike, ifb.spike, ifa.spike};
  assign a_ref = {ifc.refractory, ifb.refractory, ifa.refractory};
  assign a_pot[0] = ifa.potential;
  assign a_pot[1] = ifb.potential;
  assign a_pot[2] = ifc.potential;
  assign a_cnt[0] = ifa.spike_count;
  assign a_cnt[1] = ifb.spike_count;
  assign a_cnt[2] = ifc.spike_count;

  int th [N] = '{200, 1023, 200};
  int td [N] = '{1, 1, 3};

  // Model: potential, spike total, ticks still to skip, enabled-cycle count
  int mv [N];
  int mc [N];
  int ms [N];
  int me [N];
  int mspk [N];

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string name, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s dut%0d got %0d want %0d t=%0t",
                  name, k, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = 0; mc[k] = 0; ms[k] = 0; me[k] = 0; mspk[k] = 0;
    end
  endtask

  initial model_reset();

  always @(posedge clk) begin : model_cmp
    int n;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < N; k++) begin
        mspk[k] = 0;
        if (ena) begin
          me[k]++;
          if (me[k] % td[k] == 0) begin
            if (ms[k] > 0) begin
              ms[k]--;
            end else begin
              n = mv[k] - mv[k] / 8 + int'(cur);
              if (n > 1023) n = 1023;
              if (n >= th[k]) begin
                mv[k] = 0;
                mc[k] = (mc[k] + 1) % 256;
                mspk[k] = 1;
                ms[k] = RT;
              end else begin
                mv[k] = n;
              end
            end
          end
        end
      end
    end
    #1;
    for (int k = 0; k < N; k++) begin
      chk("spike", k, 32'(a_spk[k]), 32'(mspk[k]));
      chk("potential", k, 32'(a_pot[k]), 32'(mv[k] / 4));
      chk("refractory", k, 32'(a_ref[k]), 32'(ms[k] > 0));
      chk("spike_count", k, 32'(a_cnt[k]), 32'(mc[k]));
    end
  end

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_spike", k, 32'(a_spk[k]), 32'd0);
      chk("rst_potential", k, 32'(a_pot[k]), 32'd0);
      chk("rst_refractory", k, 32'(a_ref[k]), 32'd0);
      chk("rst_count", k, 32'(a_cnt[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int lit_a [5] = '{50, 94, 133, 167, 197};
  int lit_b [5] = '{255, 479, 675, 846, 996};

  initial begin : stim
    int cyc;
    int spikes;
    ena = 1'b1;
    cur = 8'd50;
    #2 rst_n = 1'b0;
    #1;
    chk("por_potential", 0, 32'(a_pot[0]), 32'd0);
    chk("por_spike", 0, 32'(a_spk[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-integration reset after three ticks of current 50
    repeat (3) @(negedge clk);
    chk("pre_rst_potential", 0, 32'(a_pot[0]), 32'd33);
    async_reset();

    // Integration ladder on the THRESHOLD=200 neuron
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2 chk("model_v_a", i, 32'(mv[0]), 32'(lit_a[i]));
    end
    @(posedge clk);
    #2;
    chk("model_fire_a", 0, 32'(mspk[0]), 32'd1);
    chk("dut_fire_a", 0, 32'(a_spk[0]), 32'd1);
    chk("dut_count_a", 0, 32'(a_cnt[0]), 32'd1);
    chk("dut_pot_a", 0, 32'(a_pot[0]), 32'd0);

    // Spike-to-spike period under constant current
    cyc = 0;
    do begin
      @(posedge clk);
      #2 cyc++;
    end while (!a_spk[0] && cyc < 50);
    chk("period", 0, 32'(cyc), 32'(PER));

    // Saturation on the THRESHOLD=1023 neuron
    async_reset();
    cur = 8'd255;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2 chk("model_v_b", i, 32'(mv[1]), 32'(lit_b[i]));
    end
    @(posedge clk);
    #2;
    chk("model_fire_b", 1, 32'(mspk[1]), 32'd1);
    chk("dut_fire_b", 1, 32'(a_spk[1]), 32'd1);

    // Enable freeze after the third tick
    async_reset();
    cur = 8'd50;
    repeat (3) @(negedge clk);
    ena = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #2;
      chk("frozen_spike", 0, 32'(a_spk[0]), 32'd0);
      chk("frozen_pot", 0, 32'(a_pot[0]), 32'd33);
    end
    @(negedge clk);
    ena = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #2 cyc++;
    end while (!a_spk[0] && cyc < 20);
    chk("resume_latency", 0, 32'(cyc), 32'd3);
    chk("resume_count", 0, 32'(a_cnt[0]), 32'd1);

    // spike_count wrap after 256 spikes
    async_reset();
    cur = 8'd255;
    spikes = 0;
    cyc = 0;
    while (spikes < 256 && cyc < 3000) begin
      @(posedge clk);
      #2 cyc++;
      if (a_spk[0]) spikes++;
    end
    chk("wrap_spikes", 0, 32'(spikes), 32'd256);
    chk("wrap_count", 0, 32'(a_cnt[0]), 32'd0);

    // Randomized currents, enable drops and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ena = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: cur = 8'($urandom_range(0, 255));
        1: cur = 8'($urandom_range(0, 40));
        2: cur = 8'($urandom_range(200, 255));
        default: ;
      endcase
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
